ffa_buzzer_lockout: RTL and testbench

//  Parametrised fastest-finger-first arbiter for N_PLAYERS active-low buzzer buttons.

---
 rtl/ffa_buzzer_lockout.sv | 209 ++++++++++++++++++++
 tb/tb_ffa_buzzer_lockout.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ffa_buzzer_lockout.sv
// ============================================================================
// ffa_buzzer_lockout
// ----------------------------------------------------------------------------
// Fastest-finger-first arbiter for N_PLAYERS active-low buzzer buttons.
//
// Each raw button goes through a 2-flop synchroniser and a debounce counter.
// The controller then latches the first valid press of a round and locks out
// every other player until the host clears. When several presses become valid
// on the same cycle, the lowest channel index wins.
//
// On top of the basic lockout, the controller provides:
//   - host arm/clear control,
//   - foul masking: a player already holding a button when the round is armed
//     is disqualified for that round,
//   - an optional round timeout.
//
// Parameters
//   N_PLAYERS       number of buttons/channels (1..15)
//   IDX_W           width of winner_idx; all-ones means "no winner"
//   DEBOUNCE_CYCLES consecutive synchronised low samples needed for a press
//   TIMEOUT_CYCLES  cycles spent ARMED before timing out; 0 disables it
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   btn_n         raw active-low buttons, asynchronous to clk
//   arm           start a round (acted on only in IDLE)
//   clear         end the round and return to IDLE (any state, top priority)
//   winner_valid  high while a winner is locked
//   winner_idx    zero-based winning channel, all-ones when none
//   foul_mask     channels disqualified for the current round
//   timeout       high in the TIMEOUT state
//   armed         high in the ARMED state
// ============================================================================
module ffa_buzzer_lockout #(
  parameter int N_PLAYERS       = 10,
  parameter int IDX_W           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PLAYERS-1:0] btn_n,
  input  logic                 arm,
  input  logic                 clear,
  output logic                 winner_valid,
  output logic [IDX_W-1:0]     winner_idx,
  output logic [N_PLAYERS-1:0] foul_mask,
  output logic                 timeout,
  output logic                 armed
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------

  // The debounce counter only needs to reach DEBOUNCE_CYCLES-1. The sample
  // that would take it to DEBOUNCE_CYCLES sets pressed_db instead.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int TM_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TM_W-1:0] TM_LAST =
    TM_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [IDX_W-1:0] NO_WINNER = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_LOCKED,
    ST_TIMEOUT
  } state_t;

  state_t state;

  // --------------------------------------------------------------------------
  // Input path: synchroniser and debounce
  // --------------------------------------------------------------------------

  // Both synchroniser stages reset to 1 so every channel reads as released.
  logic [N_PLAYERS-1:0] sync1;
  logic [N_PLAYERS-1:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // A press is registered after DEBOUNCE_CYCLES consecutive low samples of
  // sync2. Release is deliberately not debounced: the first high sample drops
  // the press and restarts the count.
  logic [DB_W-1:0]      db_cnt [N_PLAYERS];
  logic [N_PLAYERS-1:0] pressed_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_db <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (sync2[i]) begin
          db_cnt[i]     <= '0;
          pressed_db[i] <= 1'b0;
        end else if (db_cnt[i] >= DB_LAST) begin
          pressed_db[i] <= 1'b1;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Candidate selection
  // --------------------------------------------------------------------------

  // Only valid presses from players that are not fouled count as candidates.
  logic [N_PLAYERS-1:0] cand;
  logic [IDX_W-1:0]     first_idx;

  assign cand = pressed_db & ~foul_mask;

  // Scanning from the top down leaves the lowest set bit as the final
  // assignment, which gives the lowest-index-wins tie break.
  always_comb begin
    first_idx = NO_WINNER;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round controller
  // --------------------------------------------------------------------------

  logic [TM_W-1:0] timer;

  // Outputs are assigned together with the state transition, so every output
  // comes straight from a flop. clear beats every other event except rst.
  // foul_mask is left alone on clear so the host can still read who fouled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      winner_valid <= 1'b0;
      winner_idx   <= NO_WINNER;
      foul_mask    <= '0;
      timeout      <= 1'b0;
      armed        <= 1'b0;
      timer        <= '0;
    end else if (clear) begin
      state        <= ST_IDLE;
      winner_valid <= 1'b0;
      winner_idx   <= NO_WINNER;
      timeout      <= 1'b0;
      armed        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state     <= ST_ARMED;
            armed     <= 1'b1;
            foul_mask <= pressed_db;
            timer     <= '0;
          end
        end

        // A valid press is tested before timer expiry, so a press on the
        // expiry cycle still produces a winner.
        ST_ARMED: begin
          if (cand != '0) begin
            state        <= ST_LOCKED;
            armed        <= 1'b0;
            winner_valid <= 1'b1;
            winner_idx   <= first_idx;
          end else if (TIMEOUT_CYCLES > 0) begin
            if (timer >= TM_LAST) begin
              state   <= ST_TIMEOUT;
              armed   <= 1'b0;
              timeout <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end

        ST_LOCKED: begin
        end

        ST_TIMEOUT: begin
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ffa_buzzer_lockout.sv
// ============================================================================
// tb_ffa_buzzer_lockout
// ----------------------------------------------------------------------------
// Directed bench for ffa_buzzer_lockout.
//
// Two instances share every input:
//   dut_a  has the timeout disabled,
//   dut_b  uses TIMEOUT_CYCLES = 8.
//
// Inputs change, and outputs are sampled, 1 ns after a rising edge.
// ============================================================================
module tb_ffa_buzzer_lockout;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_n;
  logic         arm;
  logic         clear;

  logic         a_valid;
  logic [3:0]   a_idx;
  logic [N-1:0] a_foul;
  logic         a_timeout;
  logic         a_armed;

  logic         b_valid;
  logic [3:0]   b_idx;
  logic [N-1:0] b_foul;
  logic         b_timeout;
  logic         b_armed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ffa_buzzer_lockout #(
    .N_PLAYERS(N), .IDX_W(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(0)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_n(btn_n), .arm(arm), .clear(clear),
    .winner_valid(a_valid), .winner_idx(a_idx), .foul_mask(a_foul),
    .timeout(a_timeout), .armed(a_armed)
  );

  ffa_buzzer_lockout #(
    .N_PLAYERS(N), .IDX_W(4), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_n(btn_n), .arm(arm), .clear(clear),
    .winner_valid(b_valid), .winner_idx(b_idx), .foul_mask(b_foul),
    .timeout(b_timeout), .armed(b_armed)
  );

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] b, input logic a, input logic c);
    btn_n = b;
    arm   = a;
    clear = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Safety net: the directed sequence should finish long before this.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // ------------------------------------------------------------------------
    // 1. Reset held for two cycles
    // ------------------------------------------------------------------------
    rst = 1'b1;
    applyStimulus('1, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    checkOutput("rst_idx",     32'(a_idx),     32'hF);
    checkOutput("rst_valid",   32'(a_valid),   32'h0);
    checkOutput("rst_foul",    32'(a_foul),    32'h0);
    checkOutput("rst_armed",   32'(a_armed),   32'h0);
    checkOutput("rst_timeout", 32'(b_timeout), 32'h0);

    // ------------------------------------------------------------------------
    // 2. Latency: ch3 held low from edge k; winner appears after edge k+6
    // ------------------------------------------------------------------------
    applyStimulus('1, 1'b1, 1'b0);
    tick(1);
    checkOutput("arm_armed", 32'(a_armed), 32'h1);
    checkOutput("arm_foul",  32'(a_foul),  32'h0);

    applyStimulus(10'b11_1111_0111, 1'b0, 1'b0);
    tick(6);
    checkOutput("lat_early_valid", 32'(a_valid), 32'h0);
    tick(1);
    checkOutput("lat_valid", 32'(a_valid), 32'h1);
    checkOutput("lat_idx",   32'(a_idx),   32'h3);
    checkOutput("lat_armed", 32'(a_armed), 32'h0);

    // A later press on ch7 must not steal the win.
    applyStimulus(10'b11_0111_0111, 1'b0, 1'b0);
    tick(8);
    checkOutput("lock_idx", 32'(a_idx), 32'h3);

    // ------------------------------------------------------------------------
    // 6a. clear while LOCKED
    // ------------------------------------------------------------------------
    applyStimulus('1, 1'b0, 1'b1);
    tick(1);
    applyStimulus('1, 1'b0, 1'b0);
    checkOutput("clr_idx",   32'(a_idx),   32'hF);
    checkOutput("clr_valid", 32'(a_valid), 32'h0);
    tick(4);

    // ------------------------------------------------------------------------
    // 3. Tie: ch2 and ch5 fall together -> ch2 wins
    // ------------------------------------------------------------------------
    applyStimulus('1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(10'b11_1101_1011, 1'b0, 1'b0);
    tick(7);
    checkOutput("tie_valid", 32'(a_valid), 32'h1);
    checkOutput("tie_idx",   32'(a_idx),   32'h2);
    applyStimulus('1, 1'b0, 1'b1);
    tick(1);
    applyStimulus('1, 1'b0, 1'b0);
    tick(4);

    // ------------------------------------------------------------------------
    // 4a. A three-cycle glitch on ch0 is rejected
    // ------------------------------------------------------------------------
    applyStimulus('1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(10'b11_1111_1110, 1'b0, 1'b0);
    tick(3);
    applyStimulus('1, 1'b0, 1'b0);
    tick(10);
    checkOutput("glitch_valid", 32'(a_valid), 32'h0);
    checkOutput("glitch_armed", 32'(a_armed), 32'h1);
    applyStimulus('1, 1'b0, 1'b1);
    tick(1);
    applyStimulus('1, 1'b0, 1'b0);
    tick(4);

    // ------------------------------------------------------------------------
    // 4b. ch1 held at arm is fouled and never wins; ch4 then wins
    // ------------------------------------------------------------------------
    applyStimulus(10'b11_1111_1101, 1'b0, 1'b0);
    tick(8);
    applyStimulus(10'b11_1111_1101, 1'b1, 1'b0);
    tick(1);
    applyStimulus(10'b11_1111_1101, 1'b0, 1'b0);
    checkOutput("foul_mask",  32'(a_foul),  32'h002);
    checkOutput("foul_armed", 32'(a_armed), 32'h1);
    tick(10);
    checkOutput("foul_nowin", 32'(a_valid), 32'h0);

    applyStimulus(10'b11_1110_1101, 1'b0, 1'b0);
    tick(7);
    checkOutput("foul_other_valid", 32'(a_valid), 32'h1);
    checkOutput("foul_other_idx",   32'(a_idx),   32'h4);

    applyStimulus('1, 1'b0, 1'b1);
    tick(1);
    applyStimulus('1, 1'b0, 1'b0);
    checkOutput("idle_foul_hold", 32'(a_foul), 32'h002);
    tick(4);

    // ------------------------------------------------------------------------
    // 6b. clear together with arm in IDLE stays in IDLE
    // ------------------------------------------------------------------------
    applyStimulus('1, 1'b1, 1'b1);
    tick(1);
    applyStimulus('1, 1'b0, 1'b0);
    checkOutput("clrarm_armed", 32'(a_armed), 32'h0);
    checkOutput("clrarm_foul",  32'(a_foul),  32'h002);
    tick(2);
    checkOutput("clrarm_still", 32'(a_armed), 32'h0);

    // ------------------------------------------------------------------------
    // 5. Timeout on dut_b (TIMEOUT_CYCLES = 8)
    // ------------------------------------------------------------------------
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("rst2_foul", 32'(a_foul), 32'h0);

    // With no press, timeout rises at the 8th edge after the arm edge.
    applyStimulus('1, 1'b1, 1'b0);
    tick(1);
    applyStimulus('1, 1'b0, 1'b0);
    tick(7);
    checkOutput("to_early",       32'(b_timeout), 32'h0);
    checkOutput("to_early_armed", 32'(b_armed),   32'h1);
    tick(1);
    checkOutput("to_timeout", 32'(b_timeout), 32'h1);
    checkOutput("to_armed",   32'(b_armed),   32'h0);
    checkOutput("to_idx",     32'(b_idx),     32'hF);

    // arm is ignored while in TIMEOUT.
    applyStimulus('1, 1'b1, 1'b0);
    tick(2);
    checkOutput("to_hold", 32'(b_timeout), 32'h1);

    applyStimulus('1, 1'b0, 1'b1);
    tick(1);
    applyStimulus('1, 1'b0, 1'b0);
    checkOutput("to_clr", 32'(b_timeout), 32'h0);
    tick(3);

    // ch6 becomes valid exactly on the expiry cycle: the press wins.
    applyStimulus('1, 1'b1, 1'b0);
    tick(1);
    applyStimulus('1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(10'b11_1011_1111, 1'b0, 1'b0);
    tick(6);
    checkOutput("exp_early_valid", 32'(b_valid), 32'h0);
    tick(1);
    checkOutput("exp_valid",   32'(b_valid),   32'h1);
    checkOutput("exp_idx",     32'(b_idx),     32'h6);
    checkOutput("exp_timeout", 32'(b_timeout), 32'h0);

    applyStimulus('1, 1'b0, 1'b0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
